// File: rtl/ramp_seq_ctrl.sv
// Ramp sequencer: generates sawtooth or triangle ramps between configured bounds
// for a programmed number of periods, with a valid/ready configuration handshake.
module ramp_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_start,
    input  logic [WIDTH-1:0] cfg_stop,
    input  logic [WIDTH-1:0] cfg_step,
    input  logic             cfg_mode,
    input  logic [CNT_W-1:0] cfg_cycles,
    input  logic             go,
    input  logic             abort,
    output logic [WIDTH-1:0] ramp,
    output logic             ramp_valid,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [CNT_W-1:0] period_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_UP   = 2'd1,
        RUN_DOWN = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_start;
    logic [WIDTH-1:0] r_stop;
    logic [WIDTH-1:0] r_step;
    logic             r_mode;
    logic [CNT_W-1:0] r_cycles;
    logic             r_loaded;
    logic             r_err;
    logic [WIDTH-1:0] r_ramp;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_ramp_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             w_hs;
    logic             w_cfg_bad;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_up_val;
    logic [WIDTH-1:0] w_dn_val;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_last;

    assign w_hs      = cfg_valid && (r_state == IDLE);
    assign w_cfg_bad = (cfg_stop <= cfg_start) || (cfg_step == '0);

    // One extra bit on both sides so the clamp sees overflow/borrow instead of a wrap.
    assign w_sum     = {1'b0, r_ramp} + {1'b0, r_step};
    assign w_diff    = {1'b0, r_ramp} - {1'b0, r_step};
    assign w_up_val  = (w_sum >= {1'b0, r_stop}) ? r_stop : w_sum[WIDTH-1:0];
    assign w_dn_val  = (w_diff[WIDTH] || (w_diff[WIDTH-1:0] <= r_start)) ? r_start
                                                                         : w_diff[WIDTH-1:0];

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_last    = (r_cycles != '0) && (w_cnt_inc == r_cycles);

    // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_ramp_nxt  = r_ramp;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (go && r_loaded && !w_hs) begin
                    w_state_nxt = RUN_UP;
                    w_ramp_nxt  = r_start;
                    w_cnt_nxt   = '0;
                end
            end
            RUN_UP: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (r_ramp == r_stop) begin
                    if (r_mode) begin
                        w_state_nxt = RUN_DOWN;
                        w_ramp_nxt  = w_dn_val;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_last) w_state_nxt = DONE;
                        else        w_ramp_nxt  = r_start;
                    end
                end else begin
                    w_ramp_nxt = w_up_val;
                end
            end
            RUN_DOWN: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (r_ramp == r_start) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = RUN_UP;
                        w_ramp_nxt  = w_up_val;
                    end
                end else begin
                    w_ramp_nxt = w_dn_val;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ramp  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ramp  <= w_ramp_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A rejected offer flags the error but keeps whatever config was stored before.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start  <= '0;
            r_stop   <= '0;
            r_step   <= '0;
            r_mode   <= 1'b0;
            r_cycles <= '0;
            r_loaded <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_hs) begin
            if (w_cfg_bad) begin
                r_err <= 1'b1;
            end else begin
                r_start  <= cfg_start;
                r_stop   <= cfg_stop;
                r_step   <= cfg_step;
                r_mode   <= cfg_mode;
                r_cycles <= cfg_cycles;
                r_loaded <= 1'b1;
                r_err    <= 1'b0;
            end
        end
    end

    assign cfg_ready  = (r_state == IDLE);
    assign busy       = (r_state == RUN_UP) || (r_state == RUN_DOWN);
    assign ramp_valid = busy;
    assign done       = (r_state == DONE);
    assign ramp       = r_ramp;
    assign cfg_err    = r_err;
    assign period_cnt = r_cnt;

endmodule

// File: tb/tb_ramp_seq_ctrl.sv
// Directed bench for ramp_seq_ctrl: expected ramp samples are queued when a run is
// launched and popped against the DUT while ramp_valid is high.
module tb_ramp_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_start;
    logic [15:0] cfg_stop;
    logic [15:0] cfg_step;
    logic        cfg_mode;
    logic [7:0]  cfg_cycles;
    logic        go;
    logic        abort;
    logic [15:0] ramp;
    logic        ramp_valid;
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic [7:0]  period_cnt;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];

    ramp_seq_ctrl #(.WIDTH(16), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_start  (cfg_start),
        .cfg_stop   (cfg_stop),
        .cfg_step   (cfg_step),
        .cfg_mode   (cfg_mode),
        .cfg_cycles (cfg_cycles),
        .go         (go),
        .abort      (abort),
        .ramp       (ramp),
        .ramp_valid (ramp_valid),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .period_cnt (period_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Step one clock and settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [15:0] s, input logic [15:0] p, input logic [15:0] t,
                       input logic m, input logic [7:0] c);
        cfg_start  = s;
        cfg_stop   = p;
        cfg_step   = t;
        cfg_mode   = m;
        cfg_cycles = c;
        cfg_valid  = 1'b1;
        tick();
        cfg_valid  = 1'b0;
    endtask

    task automatic go_pulse();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) begin
            chk({tag, "_valid"}, 32'(ramp_valid), 1);
            chk({tag, "_ramp"}, 32'(ramp), 32'(exp_q.pop_front()));
            tick();
        end
    endtask

    task automatic push_seq(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; go = 1'b0; abort = 1'b0;
        cfg_start = '0; cfg_stop = '0; cfg_step = '0; cfg_mode = 1'b0; cfg_cycles = '0;
        tick();
        tick();
        chk("rst_ramp", 32'(ramp), 0);
        chk("rst_valid", 32'(ramp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(cfg_err), 0);
        chk("rst_cnt", 32'(period_cnt), 0);
        rst = 1'b0;
        tick();
        chk("rst_ready", 32'(cfg_ready), 1);

        // Rejected configs; go with nothing loaded must not start.
        cfg(16'd5, 16'd5, 16'd1, 1'b0, 8'd1);
        chk("bad_eq_err", 32'(cfg_err), 1);
        go_pulse();
        chk("bad_go_busy", 32'(busy), 0);
        tick();
        chk("bad_go_busy2", 32'(busy), 0);
        cfg(16'd1, 16'd9, 16'd0, 1'b0, 8'd1);
        chk("bad_step_err", 32'(cfg_err), 1);
        go_pulse();
        chk("bad_step_busy", 32'(busy), 0);

        // Sawtooth, two periods.
        cfg(16'd0, 16'd10, 16'd4, 1'b0, 8'd2);
        chk("saw_err_clr", 32'(cfg_err), 0);
        push_seq(16'd0, 16'd4, 16'd8, 16'd10);
        push_seq(16'd0, 16'd4, 16'd8, 16'd10);
        go_pulse();
        drain("saw");
        chk("saw_done", 32'(done), 1);
        chk("saw_done_valid", 32'(ramp_valid), 0);
        chk("saw_hold", 32'(ramp), 16'd10);
        chk("saw_cnt", 32'(period_cnt), 2);
        tick();
        chk("saw_done_once", 32'(done), 0);
        chk("saw_idle", 32'(cfg_ready), 1);

        // Triangle, one period, then restart from retained config.
        cfg(16'd2, 16'd8, 16'd3, 1'b1, 8'd1);
        for (int r = 0; r < 2; r++) begin
            push_seq(16'd2, 16'd5, 16'd8, 16'd5);
            exp_q.push_back(16'd2);
            go_pulse();
            drain("tri");
            chk("tri_done", 32'(done), 1);
            chk("tri_hold", 32'(ramp), 16'd2);
            chk("tri_cnt", 32'(period_cnt), 1);
            tick();
            chk("tri_idle_busy", 32'(busy), 0);
            chk("tri_idle_ready", 32'(cfg_ready), 1);
        end

        // Top-of-range clamp, continuous, abort coincident with ramp == stop.
        cfg(16'hFFF0, 16'hFFFF, 16'h0010, 1'b0, 8'd0);
        exp_q.push_back(16'hFFF0);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'hFFF0);
        go_pulse();
        drain("clamp");
        chk("clamp_top", 32'(ramp), 16'hFFFF);
        chk("clamp_cnt", 32'(period_cnt), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(ramp_valid), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_hold", 32'(ramp), 16'hFFFF);
        chk("abort_cnt", 32'(period_cnt), 1);
        tick();
        chk("abort_done2", 32'(done), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle_ready", 32'(cfg_ready), 1);

        // Continuous sawtooth 0,1,...: period counter wraps at 256.
        cfg(16'd0, 16'd1, 16'd1, 1'b0, 8'd0);
        go_pulse();
        for (int k = 0; k < 520; k++) begin
            chk("wrap_ramp", 32'(ramp), k % 2);
            chk("wrap_cnt", 32'(period_cnt), (k / 2) % 256);
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("wrap_abort", 32'(busy), 0);

        // Asynchronous reset in the middle of RUN_DOWN.
        cfg(16'd0, 16'd20, 16'd5, 1'b1, 8'd0);
        push_seq(16'd0, 16'd5, 16'd10, 16'd15);
        exp_q.push_back(16'd20);
        exp_q.push_back(16'd15);
        go_pulse();
        drain("down");
        chk("down_busy", 32'(busy), 1);
        chk("down_ramp", 32'(ramp), 16'd10);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ramp", 32'(ramp), 0);
        chk("arst_valid", 32'(ramp_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_cnt", 32'(period_cnt), 0);
        chk("arst_ready", 32'(cfg_ready), 1);
        #2;
        rst = 1'b0;
        tick();
        go_pulse();
        chk("arst_go_busy", 32'(busy), 0);
        tick();
        chk("arst_go_valid", 32'(ramp_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
